// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: turns CPU load/store requests into single-port RAM cycles.
// Partial stores become a read-modify-write pair. The block owns the bus
// direction: it drives ram_data only while its registered write enable is set.
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic                    ram_we,
  inout  wire  [DATA_WIDTH-1:0]   ram_data
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WRITE     = 3'd2,
    RMW_READ  = 3'd3,
    RMW_WRITE = 3'd4
  } state_t;

  state_t                  state_q,       state_d;
  logic [ADDR_WIDTH-1:0]   ram_address_q, ram_address_d;
  logic                    ram_we_q,      ram_we_d;
  logic [DATA_WIDTH-1:0]   wdata_q,       wdata_d;
  logic [BE_WIDTH-1:0]     be_q,          be_d;
  logic                    rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;

  // Byte-lane merge: enabled lanes take the store data, the rest keep RAM data.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   lane_en
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (lane_en[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // Ready only when idle and not being reset; a transfer needs both.
  assign req_ready = (state_q == IDLE) && !rst;

  // Next-state and next-register computation for the access sequencer.
  always_comb begin
    state_d       = state_q;
    ram_address_d = ram_address_q;
    ram_we_d      = 1'b0;
    wdata_d       = wdata_q;
    be_d          = be_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          ram_address_d = req_addr;
          wdata_d       = req_wdata;
          be_d          = req_be;
          if (!req_we) begin
            state_d = READ;
          end else if (req_be == {BE_WIDTH{1'b1}}) begin
            state_d  = WRITE;
            ram_we_d = 1'b1;
          end else if (req_be == {BE_WIDTH{1'b0}}) begin
            // Nothing to write: acknowledge without touching the RAM.
            rsp_valid_d = 1'b1;
          end else begin
            state_d = RMW_READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        rsp_rdata_d = ram_data;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RMW_READ: begin
        // Merged word is parked in wdata so the write cycle drives it directly.
        wdata_d  = merge_lanes(ram_data, wdata_q, be_q);
        ram_we_d = 1'b1;
        state_d  = RMW_WRITE;
      end
      RMW_WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ram_address_q <= {ADDR_WIDTH{1'b0}};
      ram_we_q      <= 1'b0;
      wdata_q       <= {DATA_WIDTH{1'b0}};
      be_q          <= {BE_WIDTH{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      ram_address_q <= ram_address_d;
      ram_we_q      <= ram_we_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign ram_address = ram_address_q;
  assign ram_we      = ram_we_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

  // Write enable and bus output enable share one flop, so no contention.
  assign ram_data = ram_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: directed scenarios plus random
// traffic checked against a word-level memory model.
module tb_ram_access_ctrl;

  localparam int AW    = 17;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_address;
  logic          ram_we;
  wire  [DW-1:0] ram_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rsp_cyc  = 0;

  logic [DW-1:0] ram_mem [0:DEPTH-1];
  logic          ram_init_done = 1'b0;
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] last_rd = 32'h0;

  ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .ram_address (ram_address),
    .ram_we      (ram_we),
    .ram_data    (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return ({15'h0, a} * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // Behavioural single-port RAM: asynchronous read onto the bus, write at edge.
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i[AW-1:0]);
      ram_init_done <= 1'b1;
    end else if (ram_we === 1'b1) begin
      ram_mem[ram_address] <= ram_data;
    end
  end

  assign ram_data = (ram_we === 1'b1) ? {DW{1'bz}} : ram_mem[ram_address];

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    else n_pass++;
  endtask

  // One complete request/response transaction; starts and ends at a negedge.
  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [3:0] be);
    int waitc, lat, exp_lat, we_cyc, bus_bad;
    logic [DW-1:0] old_w, new_w;
    old_w = ref_read(addr);
    new_w = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
    if (!we)            exp_lat = 2;
    else if (be == 4'hF) exp_lat = 2;
    else if (be == 4'h0) exp_lat = 1;
    else                 exp_lat = 3;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    waitc = 0;
    while (req_ready !== 1'b1 && waitc < 20) begin @(negedge clk); waitc++; end
    check_eq("xfer_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = AW'($urandom);
    req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1; we_cyc = 0; bus_bad = 0;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      if (ram_we === 1'b1) begin
        we_cyc++;
        if (ram_data !== new_w || ram_address !== addr) bus_bad++;
      end else if (ram_data !== ram_mem[ram_address]) begin
        bus_bad++;
      end
      @(negedge clk); lat++;
    end
    rsp_cyc = cyc;
    check_eq("rsp_seen", {31'h0, rsp_valid}, 32'h1);
    check_eq("latency", lat, exp_lat);
    check_eq("we_cycles", we_cyc, (we && be != 4'h0) ? 1 : 0);
    check_eq("bus_ok", bus_bad, 0);
    check_eq("ready_with_rsp", {31'h0, req_ready}, 32'h1);
    if (we) ref_mem[int'(addr)] = new_w;
    else    last_rd = old_w;
    check_eq(we ? "rdata_held" : "load_data", rsp_rdata, last_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int prev;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h1ABCD;
    req_wdata = 32'h0; req_be = 4'h0;

    // Reset held three cycles with a request pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_ready", {31'h0, req_ready}, 32'h0);
      check_eq("rst_we",    {31'h0, ram_we},    32'h0);
      check_eq("rst_rsp",   {31'h0, rsp_valid}, 32'h0);
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_addr",  {15'h0, ram_address}, 32'h0);
    check_eq("post_rst_rdata", rsp_rdata, 32'h0);
    check_eq("post_rst_rsp",   {31'h0, rsp_valid}, 32'h0);
    check_eq("post_rst_ready", {31'h0, req_ready}, 32'h1);

    // Full store then load.
    do_req(1'b1, 17'h00010, 32'hDEAD_BEEF, 4'hF);
    do_req(1'b0, 17'h00010, 32'h0, 4'h0);
    check_eq("load_deadbeef", rsp_rdata, 32'hDEAD_BEEF);

    // Partial store over a known word.
    do_req(1'b1, 17'h00005, 32'h1122_3344, 4'hF);
    do_req(1'b1, 17'h00005, 32'hAABB_CCDD, 4'b0101);
    do_req(1'b0, 17'h00005, 32'h0, 4'h0);
    check_eq("rmw_result", rsp_rdata, 32'h11BB_33DD);

    // Zero byte-enable store: ack only, RAM untouched.
    do_req(1'b1, 17'h00003, 32'hFFFF_FFFF, 4'h0);
    check_eq("be0_ram", ram_mem[3], init_word(17'h00003));

    // Back-to-back loads, one response every two cycles.
    do_req(1'b0, 17'h00010, 32'h0, 4'h0);
    prev = rsp_cyc;
    do_req(1'b0, 17'h00005, 32'h0, 4'h0);
    check_eq("b2b_gap1", rsp_cyc - prev, 2); prev = rsp_cyc;
    do_req(1'b0, 17'h00003, 32'h0, 4'h0);
    check_eq("b2b_gap2", rsp_cyc - prev, 2); prev = rsp_cyc;
    do_req(1'b0, 17'h1FFFF, 32'h0, 4'h0);
    check_eq("b2b_gap3", rsp_cyc - prev, 2);

    // Reset during RMW_READ: request aborted, RAM unchanged.
    v = ref_read(17'h00007);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 17'h00007;
    req_wdata = 32'h5555_AAAA; req_be = 4'b0011;
    check_eq("abort_rmw_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_rmw_we0", {31'h0, ram_we}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_rmw_rsp", {31'h0, rsp_valid}, 32'h0);
    check_eq("abort_rmw_we",  {31'h0, ram_we},    32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_rmw_idle", {31'h0, req_ready}, 32'h1);
    check_eq("abort_rmw_rsp2", {31'h0, rsp_valid}, 32'h0);
    check_eq("abort_rmw_ram",  ram_mem[7], v);
    do_req(1'b0, 17'h00007, 32'h0, 4'h0);

    // Reset during WRITE: the write already on the bus still lands.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 17'h00009;
    req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_wr_we1", {31'h0, ram_we}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_wr_rsp", {31'h0, rsp_valid}, 32'h0);
    ref_mem[9] = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("abort_wr_rsp2", {31'h0, rsp_valid}, 32'h0);
    do_req(1'b0, 17'h00009, 32'h0, 4'h0);

    // Random traffic against the word-level model.
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      logic [3:0]    b;
      int            r;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      r = $urandom_range(0, 3);
      b = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom);
      r = $urandom_range(0, 2);
      for (int g = 0; g < r; g++) @(negedge clk);
      do_req($urandom_range(0, 1) == 1, a, $urandom, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
